fu_load_queue: RTL
==================

# fu_load_queue

Multi-entry, parametrised load functional unit that replaces the single-slot load FU. It accepts issued loads into an LQ_DEPTH-entry buffer and keeps several loads in flight at once. Each load goes through store-queue forwarding lookup, cache access and, on a miss, waiting for a tagged cache broadcast. Results go to the complete stage one per cycle. It sits between the issue stage (load FU slot), the SQ lookup port, the D-cache read port and the complete stage.

## Interface
- LQ_DEPTH, 4: number of load buffer entries (power of 2, ≥2).
- TAG_W, $clog2(LQ_DEPTH)+1: miss tag width, {generation bit, entry index}.

- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- squash  in  1  flush all entries (mispredict); synchronous.
- complete_stall  in  1  complete stage cannot take a result this cycle.
- fu_packet_in  in  ISSUE_FU_PACKET  issued load; valid bit inside.
- fu_ready  out  1  at least one free entry.
- want_to_complete  out  1  fu_packet_out holds a finished load.
- fu_packet_out  out  FU_COMPLETE_PACKET  result (dest_pr, rob_entry, dest_value, valid).
- sq_lookup  out  LOAD_SQ_PACKET  word-aligned addr and tail_pos of the granted entry.
- sq_lookup_valid  out  1  sq_lookup is meaningful.
- sq_result  in  SQ_LOAD_PACKET  stall, usebytes[3:0], data; combinational response to sq_lookup.
- addr  out  XLEN  word-aligned cache read address.
- cache_read_EN  out  1  cache read request this cycle.
- cache_read_tag  out  TAG_W  tag of the requesting entry.
- is_hit  in  1  same-cycle hit for the current request.
- cache_data_in  in  XLEN  hit data.
- broadcast_en  in  1  miss fill returning.
- broadcast_tag  in  TAG_W  tag of the returning fill.
- broadcast_data  in  XLEN  fill word.

## Operation
- Entry states: FREE, WAIT_SQ, WAIT_CACHE, WAIT_MISS, DONE. Each entry stores:
  - result packet
  - full byte address
  - ls op
  - usebytes
  - forward_bytes
  - aligned_data
  - gen bit
- Allocate:
  - Condition: fu_packet_in.valid and fu_ready.
  - Target: the lowest-index FREE entry. It goes to WAIT_SQ and its gen bit toggles.
  - Address = r1_value + sign-extended I-immediate.
  - usebytes: LB/LBU give a one-hot byte from addr[1:0]. LH/LHU give 0011 or 1100 from addr[1]. LW gives 1111.
- SQ port:
  - Grant: one entry per cycle, round-robin among WAIT_SQ entries, starting after the last grant.
  - sq_result.stall: the entry stays in WAIT_SQ.
  - Otherwise: capture forward_bytes = sq_result.usebytes and aligned_data = sq_result.data.
  - Next state: DONE if (usebytes & forward_bytes) == usebytes, else WAIT_CACHE.
- Cache port:
  - Grant: one entry per cycle, round-robin among WAIT_CACHE entries. cache_read_EN = 1 with addr and cache_read_tag.
  - is_hit: merge cache_data_in with the forwarded bytes (forwarded bytes win), then go to DONE.
  - Miss: go to WAIT_MISS.
- Miss return: broadcast_en with broadcast_tag equal to {gen, index} of an entry in WAIT_MISS causes a merge of broadcast_data and a move to DONE. Non-matching broadcasts are ignored.
- Output:
  - Selection: lowest-index DONE entry drives fu_packet_out; want_to_complete = 1.
  - If ~complete_stall, that entry goes to FREE at the next edge.
- Write-back extraction:
  - LB/LH sign-extend the selected byte or half.
  - LBU/LHU zero-extend it into the low bits; LHU with addr[1]=1 returns the upper half in [15:0].
  - LW returns the full word.
- squash: all entries go to FREE next edge. Squash has priority over allocate, grant, hit and broadcast in the same cycle. Late broadcasts for squashed tags never match, because of the gen bit.
- A same-cycle free and allocate of the same entry is allowed; fu_ready reflects only the current-cycle FREE count.

## Timing
- Reset values: all entries FREE, gen bits 0, round-robin pointers 0. fu_ready = 1; want_to_complete, cache_read_EN and sq_lookup_valid are 0; fu_packet_out = 0.
- No-contention latency, load issued in cycle t:
  - SQ lookup in t+1.
  - Cache request in t+2.
  - want_to_complete in t+3 on a hit.
  - Full SQ forward: want_to_complete in t+2.
- Miss: want_to_complete one cycle after the matching broadcast_en.
- All outputs except sq_lookup/addr/cache_read_EN/cache_read_tag are registered-state decodes. sq_lookup, addr, cache_read_EN and cache_read_tag come from combinational arbitration over registered state.
- Full: fu_ready = 0 when no entry is FREE. An issue while full is a protocol violation and is dropped.
- Reset mid-operation: everything is discarded and in-flight miss tags are forgotten.

## Configuration
- LOADQ_HIT_BYPASS_EN defined:
  - A cache hit whose entry would be the selected output is driven straight to fu_packet_out in the same cycle it hits. The selected-output condition is: no other entry in DONE and ~complete_stall.
  - The entry then goes FREE directly, giving hit latency t+2.
  - If the bypass cannot fire, the entry goes to DONE as normal.
- Not defined: hits always go through DONE (t+3).

## Test plan
- Single LW: addr 0x100, no SQ forward, hit with data 0xDEADBEEF -> want_to_complete at t+3, dest_value 0xDEADBEEF.
- LB at 0x103 with a partial SQ forward of byte 3 = 0x80, cache word 0x11223344 -> dest_value 0xFFFFFF80. LHU at 0x102, cache 0xABCD0000 -> dest_value 0x0000ABCD.
- Fill all 4 entries with misses, then return broadcasts for tags 2, 0, 3, 1 -> fu_ready = 0 until the first completion; completions occur in broadcast order.
- Miss pending on entry 0 (tag 0b0_00), then squash, re-issue into entry 0 (tag 0b1_00), then stale broadcast tag 0b0_00 -> ignored; the entry completes only on tag 0b1_00.
- Hold complete_stall high for 5 cycles with 2 entries in DONE -> fu_packet_out stays stable on entry 0; after release, entries 0 and 1 complete on consecutive cycles.
- SQ stall for 3 cycles, then full forward of 0x0000007F for LB at 0x200 -> no cache_read_EN issued; dest_value 0x7F.

Source files
------------

// File: rtl/fu_load_queue.sv
// Multi-entry load queue: SQ forwarding lookup, D-cache access, tagged miss return, lowest-index completion.
// Optional feature macro LOADQ_HIT_BYPASS_EN: a hit that would be the selected output completes the same cycle.
package fu_load_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] r1_value;
    logic [11:0]     imm;
    logic [2:0]      ls_op;
    logic [5:0]      dest_pr;
    logic [4:0]      rob_entry;
    logic [2:0]      tail_pos;
  } ISSUE_FU_PACKET;

  typedef struct packed {
    logic            valid;
    logic [5:0]      dest_pr;
    logic [4:0]      rob_entry;
    logic [XLEN-1:0] dest_value;
  } FU_COMPLETE_PACKET;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [2:0]      tail_pos;
  } LOAD_SQ_PACKET;

  typedef struct packed {
    logic            stall;
    logic [3:0]      usebytes;
    logic [XLEN-1:0] data;
  } SQ_LOAD_PACKET;
endpackage

module fu_load_queue
  import fu_load_queue_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int TAG_W    = $clog2(LQ_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  logic              complete_stall,
  input  ISSUE_FU_PACKET    fu_packet_in,
  output logic              fu_ready,
  output logic              want_to_complete,
  output FU_COMPLETE_PACKET fu_packet_out,
  output LOAD_SQ_PACKET     sq_lookup,
  output logic              sq_lookup_valid,
  input  SQ_LOAD_PACKET     sq_result,
  output logic [XLEN-1:0]   addr,
  output logic              cache_read_EN,
  output logic [TAG_W-1:0]  cache_read_tag,
  input  logic              is_hit,
  input  logic [XLEN-1:0]   cache_data_in,
  input  logic              broadcast_en,
  input  logic [TAG_W-1:0]  broadcast_tag,
  input  logic [XLEN-1:0]   broadcast_data
);
  localparam int IDX_W = $clog2(LQ_DEPTH);
  typedef enum logic [2:0] {FREE, WAIT_SQ, WAIT_CACHE, WAIT_MISS, DONE} lq_state_e;

  lq_state_e       state_q [LQ_DEPTH];
  lq_state_e       state_d [LQ_DEPTH];
  logic [XLEN-1:0] addr_q [LQ_DEPTH], addr_d [LQ_DEPTH];
  logic [XLEN-1:0] data_q [LQ_DEPTH], data_d [LQ_DEPTH];
  logic [2:0]      op_q [LQ_DEPTH], op_d [LQ_DEPTH];
  logic [3:0]      use_q [LQ_DEPTH], use_d [LQ_DEPTH];
  logic [3:0]      fwd_q [LQ_DEPTH], fwd_d [LQ_DEPTH];
  logic [5:0]      pr_q [LQ_DEPTH], pr_d [LQ_DEPTH];
  logic [4:0]      rob_q [LQ_DEPTH], rob_d [LQ_DEPTH];
  logic [2:0]      tail_q [LQ_DEPTH], tail_d [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] gen_q, gen_d;
  logic [IDX_W-1:0] sq_ptr_q, sq_ptr_d, c_ptr_q, c_ptr_d;

  logic [TAG_W-1:0]    tag_of [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] bcast_hit;
  logic                any_free, any_done, sq_any, c_any;
  logic [IDX_W-1:0]    free_idx, done_sel, sq_grant, c_grant, sq_idx, c_idx;
  logic [XLEN-1:0]     alloc_addr, hit_word;

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] base, input logic [3:0] fwd,
                                            input logic [XLEN-1:0] fdata);
    logic [XLEN-1:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = fwd[b] ? fdata[8*b +: 8] : base[8*b +: 8];
    return m;
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w, input logic [2:0] op,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LBU:  return {24'b0, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] use_mask(input logic [2:0] op, input logic [1:0] off);
    case (op)
      F3_LB, F3_LBU: return 4'b0001 << off;
      F3_LH, F3_LHU: return off[1] ? 4'b1100 : 4'b0011;
      default:       return 4'b1111;
    endcase
  endfunction

  // gen_q flips on every allocation; the live tag carries the value from before the flip,
  // so the first load into an entry after reset uses generation 0.
  for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_entry
    assign tag_of[gi]    = {~gen_q[gi], IDX_W'(gi)};
    assign bcast_hit[gi] = broadcast_en && (state_q[gi] == WAIT_MISS) && (broadcast_tag == tag_of[gi]);
  end

  always_comb begin
    any_free = 1'b0; free_idx = '0; any_done = 1'b0; done_sel = '0;
    for (int i = LQ_DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin any_free = 1'b1; free_idx = IDX_W'(i); end
      if (state_q[i] == DONE) begin any_done = 1'b1; done_sel = IDX_W'(i); end
    end
  end

  // Round-robin: scan from the pointer upward, nearest match wins.
  always_comb begin
    sq_any = 1'b0; sq_grant = '0; c_any = 1'b0; c_grant = '0; sq_idx = '0; c_idx = '0;
    for (int k = LQ_DEPTH - 1; k >= 0; k--) begin
      sq_idx = sq_ptr_q + IDX_W'(k);
      c_idx  = c_ptr_q + IDX_W'(k);
      if (state_q[sq_idx] == WAIT_SQ)   begin sq_any = 1'b1; sq_grant = sq_idx; end
      if (state_q[c_idx] == WAIT_CACHE) begin c_any = 1'b1;  c_grant = c_idx;   end
    end
  end

  assign alloc_addr = fu_packet_in.r1_value + {{(XLEN-12){fu_packet_in.imm[11]}}, fu_packet_in.imm};
  assign hit_word   = merge(cache_data_in, fwd_q[c_grant], data_q[c_grant]);

`ifdef LOADQ_HIT_BYPASS_EN
  logic bypass_fire;
  assign bypass_fire = c_any && is_hit && !any_done && !complete_stall;
`endif

  always_comb begin
    for (int i = 0; i < LQ_DEPTH; i++) begin
      state_d[i] = state_q[i]; addr_d[i] = addr_q[i]; data_d[i] = data_q[i]; op_d[i] = op_q[i];
      use_d[i] = use_q[i]; fwd_d[i] = fwd_q[i]; pr_d[i] = pr_q[i]; rob_d[i] = rob_q[i]; tail_d[i] = tail_q[i];
      if (bcast_hit[i]) begin
        data_d[i]  = merge(broadcast_data, fwd_q[i], data_q[i]);
        state_d[i] = DONE;
      end
    end
    gen_d = gen_q; sq_ptr_d = sq_ptr_q; c_ptr_d = c_ptr_q;
    if (sq_any) begin
      sq_ptr_d = sq_grant + IDX_W'(1);
      if (!sq_result.stall) begin
        fwd_d[sq_grant]   = sq_result.usebytes;
        data_d[sq_grant]  = sq_result.data;
        state_d[sq_grant] = ((use_q[sq_grant] & sq_result.usebytes) == use_q[sq_grant]) ? DONE : WAIT_CACHE;
      end
    end
    if (c_any) begin
      c_ptr_d = c_grant + IDX_W'(1);
      if (is_hit) begin
        data_d[c_grant]  = hit_word;
        state_d[c_grant] = DONE;
`ifdef LOADQ_HIT_BYPASS_EN
        if (bypass_fire) state_d[c_grant] = FREE;
`endif
      end else begin
        state_d[c_grant] = WAIT_MISS;
      end
    end
    if (any_done && !complete_stall) state_d[done_sel] = FREE;
    if (fu_packet_in.valid && any_free) begin
      state_d[free_idx] = WAIT_SQ;
      gen_d[free_idx]   = ~gen_q[free_idx];
      addr_d[free_idx]  = alloc_addr;
      op_d[free_idx]    = fu_packet_in.ls_op;
      use_d[free_idx]   = use_mask(fu_packet_in.ls_op, alloc_addr[1:0]);
      fwd_d[free_idx]   = 4'b0000;
      pr_d[free_idx]    = fu_packet_in.dest_pr;
      rob_d[free_idx]   = fu_packet_in.rob_entry;
      tail_d[free_idx]  = fu_packet_in.tail_pos;
    end
    if (squash) for (int i = 0; i < LQ_DEPTH; i++) state_d[i] = FREE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LQ_DEPTH; i++) state_q[i] <= FREE;
      gen_q <= '0; sq_ptr_q <= '0; c_ptr_q <= '0;
    end else begin
      for (int i = 0; i < LQ_DEPTH; i++) state_q[i] <= state_d[i];
      gen_q <= gen_d; sq_ptr_q <= sq_ptr_d; c_ptr_q <= c_ptr_d;
    end
    for (int i = 0; i < LQ_DEPTH; i++) begin
      addr_q[i] <= addr_d[i]; data_q[i] <= data_d[i]; op_q[i] <= op_d[i]; use_q[i] <= use_d[i];
      fwd_q[i] <= fwd_d[i]; pr_q[i] <= pr_d[i]; rob_q[i] <= rob_d[i]; tail_q[i] <= tail_d[i];
    end
  end

  assign fu_ready        = any_free;
  assign sq_lookup_valid = sq_any;
  assign cache_read_EN   = c_any;
  assign cache_read_tag  = c_any ? tag_of[c_grant] : '0;
  assign addr            = c_any ? {addr_q[c_grant][XLEN-1:2], 2'b00} : '0;

  always_comb begin
    sq_lookup = '0;
    if (sq_any) begin
      sq_lookup.addr     = {addr_q[sq_grant][XLEN-1:2], 2'b00};
      sq_lookup.tail_pos = tail_q[sq_grant];
    end
  end

  always_comb begin
    fu_packet_out    = '0;
    want_to_complete = 1'b0;
    if (any_done) begin
      want_to_complete         = 1'b1;
      fu_packet_out.valid      = 1'b1;
      fu_packet_out.dest_pr    = pr_q[done_sel];
      fu_packet_out.rob_entry  = rob_q[done_sel];
      fu_packet_out.dest_value = extract(data_q[done_sel], op_q[done_sel], addr_q[done_sel][1:0]);
    end
`ifdef LOADQ_HIT_BYPASS_EN
    else if (bypass_fire) begin
      want_to_complete         = 1'b1;
      fu_packet_out.valid      = 1'b1;
      fu_packet_out.dest_pr    = pr_q[c_grant];
      fu_packet_out.rob_entry  = rob_q[c_grant];
      fu_packet_out.dest_value = extract(hit_word, op_q[c_grant], addr_q[c_grant][1:0]);
    end
`endif
  end
endmodule
